// File: rtl/instr_fetch_unit.sv
// Buffered instruction fetch front end: credit-limited sequential word fetch into
// a first-word-fall-through prefetch FIFO, with redirect flush of stale fetches.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH_POW = 6,
  parameter int unsigned FIFO_DEPTH_POW = 2,
  parameter logic [(1<<ADDR_WIDTH_POW)-1:0] RESET_PC = '0
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  output logic                             mem_req_valid_out,
  input  logic                             mem_req_ready_in,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]   mem_req_addr_out,
  input  logic                             mem_rsp_valid_in,
  input  logic [31:0]                      mem_rsp_data_in,
  output logic                             instr_valid_out,
  input  logic                             instr_ready_in,
  output logic [31:0]                      instr_out,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]   instr_pc_out,
  input  logic                             redirect_valid_in,
  input  logic [(1<<ADDR_WIDTH_POW)-1:0]   redirect_pc_in
);
  localparam int unsigned AW    = 1 << ADDR_WIDTH_POW;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_POW;
  localparam int unsigned CW    = FIFO_DEPTH_POW + 1;
  localparam int unsigned PW    = FIFO_DEPTH_POW;
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_rsp_pc;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_run;
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_pc   [DEPTH];

  logic [CW:0]   w_sum;
  logic          w_req_fire;
  logic          w_out_fire;
  logic          w_drop_rsp;
  logic          w_push;
  logic [AW-1:0] w_redirect_pc;
  logic          w_unused_pc_lsb;

  // Every accepted request holds a credit until its entry leaves the FIFO or is dropped
  assign w_sum = {1'b0, r_live} + {1'b0, r_drop} + {1'b0, r_count};
  assign mem_req_valid_out = r_run && (w_sum < DEPTH_SUM);
  assign mem_req_addr_out  = r_fetch_pc;

  assign w_req_fire    = mem_req_valid_out & mem_req_ready_in;
  assign w_out_fire    = instr_valid_out & instr_ready_in;
  assign w_drop_rsp    = mem_rsp_valid_in & (r_drop != '0);
  assign w_push        = mem_rsp_valid_in & (r_drop == '0) & ~redirect_valid_in;
  assign w_redirect_pc = {redirect_pc_in[AW-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_in[1:0];

  assign instr_valid_out = (r_count != '0);
  assign instr_out       = instr_valid_out ? r_data[r_rd_ptr] : '0;
  assign instr_pc_out    = instr_valid_out ? r_pc[r_rd_ptr]   : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid_in) begin
        // Everything still in flight, including a request fired now, becomes stale
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop     <= r_drop + r_live + CW'(w_req_fire) - CW'(mem_rsp_valid_in);
        r_live     <= '0;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + AW'(4);
        if (w_push)     r_rsp_pc   <= r_rsp_pc + AW'(4);
        if (w_drop_rsp) r_drop     <= r_drop - ONE;
        r_live  <= r_live + CW'(w_req_fire) - CW'(w_push);
        r_count <= r_count + CW'(w_push) - CW'(w_out_fire);
        if (w_push)     r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_out_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push && !rst_in) begin
      r_data[r_wr_ptr] <= mem_rsp_data_in;
      r_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the single-cycle core. Replaces the core's combinational instruction-memory lookup with a buffered fetch path.
- Issues sequential word fetches to a variable-latency instruction memory port. Responses return in order and are held in a small prefetch FIFO.
- Presents {instruction, PC} pairs to the core over a valid/ready handshake. This feeds the core's instruction input in VERIFY_MODE-style integration.
- Accepts PC redirects (taken branch) from the core and discards stale in-flight fetches.

Parameters:
- ADDR_WIDTH_POW, 6, PC/address width = 1 << ADDR_WIDTH_POW (64 bits).
- FIFO_DEPTH_POW, 2, prefetch depth = 1 << FIFO_DEPTH_POW entries; also the maximum number of outstanding requests.
- RESET_PC, 0, first fetch address after reset. Must be 4-byte aligned.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous active-high reset.
- mem_req_valid_out  output  1  fetch request valid.
- mem_req_ready_in  input  1  memory accepts the request this cycle.
- mem_req_addr_out  output  ADDR_WIDTH  byte address of the word requested.
- mem_rsp_valid_in  input  1  one response word this cycle; in order, one per accepted request, latency >= 1 cycle, no backpressure.
- mem_rsp_data_in  input  32  instruction word.
- instr_valid_out  output  1  FIFO head valid.
- instr_ready_in  input  1  core consumes the head.
- instr_out  output  32  head instruction.
- instr_pc_out  output  ADDR_WIDTH  PC of the head instruction.
- redirect_valid_in  input  1  branch taken; restart fetch.
- redirect_pc_in  input  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (rst_in=1 at an edge), dominates all other inputs:
  - fetch_pc = RESET_PC; FIFO empty; live_cnt = 0; drop_cnt = 0.
  - mem_req_valid_out = 0, instr_valid_out = 0.
  - instr_out and instr_pc_out = 0 while empty.
  - In-flight responses arriving after reset are NOT dropped; the memory is reset together with this block.
- Counters:
  - live_cnt: accepted requests not yet returned that will be kept.
  - drop_cnt: requests not yet returned that will be discarded.
  - count: FIFO occupancy.
  - All are FIFO_DEPTH_POW+1 bits wide.
- Request issue:
  - mem_req_valid_out = (live_cnt + drop_cnt + count < DEPTH). It is a function of registered state only, with no combinational path from any input.
  - mem_req_addr_out = fetch_pc.
  - Request fire = valid && ready; on fire, fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH.
  - valid never deasserts without a fire, except on redirect/reset. On redirect the address changes the next cycle.
- Response:
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: write {data, pc} into the FIFO tail and decrement live_cnt.
  - The PC for each entry comes from a parallel PC queue, or equivalently head_pc tracking.
  - Written entry is visible on instr_* the cycle after arrival. There is no same-cycle bypass.
- Output:
  - First-word fall-through. instr_valid_out = (count != 0).
  - Fire = valid && ready pops the head.
  - Data and PC are stable while valid && !ready.
- Redirect (redirect_valid_in=1, no reset):
  - Any output fire in the same cycle is a valid consumption.
  - FIFO is cleared at the edge, count = 0.
  - drop_cnt_next = drop_cnt + live_cnt + req_fire - rsp_fire. A response arriving in the redirect cycle is discarded.
  - live_cnt_next = 0.
  - fetch_pc_next = {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00}. A request fired in the redirect cycle is counted in drop_cnt.
  - New requests may issue from the next cycle at the new PC, subject to the credit rule.
- Simultaneous push and pop with a full FIFO cannot overflow, because the credit rule guarantees space for every live response.
- No-redirect invariant: live_cnt + count <= DEPTH, and fetch returns are sequential PCs.

Test Plan:
- Reset then stream: RESET_PC=0x100, memory latency 2, instr_ready_in=1 -> requests 0x100, 0x104, 0x108...; instr_pc_out matches each word; steady state reaches 1 instruction/cycle after the initial latency.
- Backpressure: instr_ready_in=0 for 20 cycles -> exactly 4 requests issued (DEPTH=4), mem_req_valid_out stays 0, FIFO holds 0x100..0x10C unchanged. Release ready -> in-order drain, and fetch resumes.
- Redirect with in-flight: 3 outstanding, redirect_pc_in=0x2003 -> next request address is 0x2000; the 3 stale responses never appear on instr_out; first output pc = 0x2000.
- Simultaneous redirect + response + request fire in one cycle -> the response is dropped, drop_cnt accounts for the fired request, and no stale PC is output.
- PC wrap: redirect to 2^64-4 -> requests 0xFFFF_FFFF_FFFF_FFFC then 0x0; instr_pc_out follows the wrap.
- Reset mid-operation: FIFO full with rst_in asserted for 1 cycle -> the next cycle instr_valid_out=0 and mem_req_valid_out=0; the following cycle a request is issued to RESET_PC.
